// File: rtl/swervolf_sseg_scan_if.sv
// swervolf_sseg_scan_if
// Bundles the seven-segment scan controller's data/control inputs and its
// display pin outputs.
//   i_en     scan enable
//   i_value  4*DIGITS hex nibbles, nibble k drives digit k
//   i_dp     per-digit decimal point, 1 = lit
//   o_an     anode enables, active-low
//   o_seg    segments CA..CG (bit0..bit6), active-low
//   o_dp     decimal point, active-low
//   o_frame  one-cycle pulse when a new snapshot is taken
// master: the block feeding display data; slave: the scan controller.
interface swervolf_sseg_scan_if #(
  parameter int DIGITS = 8
);
  logic                  i_en;
  logic [4*DIGITS-1:0]   i_value;
  logic [DIGITS-1:0]     i_dp;
  logic [DIGITS-1:0]     o_an;
  logic [6:0]            o_seg;
  logic                  o_dp;
  logic                  o_frame;

  modport master (
    output i_en, i_value, i_dp,
    input  o_an, o_seg, o_dp, o_frame
  );

  modport slave (
    input  i_en, i_value, i_dp,
    output o_an, o_seg, o_dp, o_frame
  );
endinterface

// File: rtl/swervolf_sseg_scan.sv
// swervolf_sseg_scan
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. Each digit slot is PRESCALE cycles: PRESCALE-BLANK_CYCLES cycles
// lit, then BLANK_CYCLES cycles with all anodes off to avoid ghosting.
// Display data is snapshotted once per frame (o_frame pulses on the same edge).
// Ports:
//   clk  core clock
//   rst  asynchronous reset, active-high
//   bus  swervolf_sseg_scan_if.slave (i_en, i_value, i_dp -> o_an, o_seg,
//        o_dp, o_frame); all outputs registered.
// Optional feature: define SWERVOLF_SSEG_LZB_EN for leading-zero blanking.
// Digits above the most significant non-zero nibble are kept dark unless
// their decimal point is lit; digit 0 is always shown.
//
// state | meaning
// IDLE  | scan disabled, outputs dark
// ON    | current digit driven
// BLANK | inter-digit gap, outputs dark
module swervolf_sseg_scan #(
  parameter int DIGITS       = 8,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  swervolf_sseg_scan_if.slave bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     ON_LAST    = CW'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [CW-1:0]     BL_LAST    = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [DW-1:0]     LAST_DIGIT = DW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF     = '1;
  localparam logic [DIGITS-1:0] AN_DIGIT0  = ~(DIGITS'(1));
  localparam logic [6:0]        SEG_OFF    = 7'h7F;

  typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  state_t              state;
  logic [DW-1:0]       digit;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] shadow_value;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic                frame_q;

`ifdef SWERVOLF_SSEG_LZB_EN
  logic [DIGITS-1:0]   shadow_mask;
  logic [DIGITS-1:0]   snap_mask;
  logic                nz;

  // A digit is blankable when it and every nibble above it are zero.
  always_comb begin
    snap_mask = '0;
    nz        = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      nz           = nz | (|bus.i_value[4*k +: 4]);
      snap_mask[k] = ~nz;
    end
  end
`endif

  // Output values for the slot that follows the current one. On wrap the new
  // snapshot is taken on the same edge, so digit 0 decodes straight from the
  // inputs rather than from the shadow registers.
  logic                wrap;
  logic [DW-1:0]       step_digit;
  logic [DIGITS-1:0]   step_onehot;
  logic [4*DIGITS-1:0] step_shift;
  logic [3:0]          step_nib;
  logic                step_dpin;
  logic                step_blank;
  logic [6:0]          snap_seg;
  logic                snap_dp;
  logic [DIGITS-1:0]   adv_an;
  logic [6:0]          adv_seg;
  logic                adv_dp;

  always_comb begin
    wrap        = (digit == LAST_DIGIT);
    step_digit  = digit + DW'(1);
    step_onehot = DIGITS'(1) << step_digit;
    step_shift  = shadow_value >> {step_digit, 2'b00};
    step_nib    = step_shift[3:0];
    step_dpin   = |(shadow_dp & step_onehot);
`ifdef SWERVOLF_SSEG_LZB_EN
    step_blank  = (|(shadow_mask & step_onehot)) & ~step_dpin;
`else
    step_blank  = 1'b0;
`endif
    snap_seg    = decode(bus.i_value[3:0]);
    snap_dp     = ~bus.i_dp[0];
    if (wrap) begin
      adv_an  = AN_DIGIT0;
      adv_seg = snap_seg;
      adv_dp  = snap_dp;
    end else if (step_blank) begin
      adv_an  = AN_OFF;
      adv_seg = SEG_OFF;
      adv_dp  = 1'b1;
    end else begin
      adv_an  = ~step_onehot;
      adv_seg = decode(step_nib);
      adv_dp  = ~step_dpin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      digit        <= '0;
      cnt          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
`ifdef SWERVOLF_SSEG_LZB_EN
      shadow_mask  <= '0;
`endif
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (!bus.i_en) begin
        state <= IDLE;
        digit <= '0;
        cnt   <= '0;
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
        dp_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state        <= ON;
            digit        <= '0;
            cnt          <= '0;
            shadow_value <= bus.i_value;
            shadow_dp    <= bus.i_dp;
`ifdef SWERVOLF_SSEG_LZB_EN
            shadow_mask  <= snap_mask;
`endif
            frame_q      <= 1'b1;
            an_q         <= AN_DIGIT0;
            seg_q        <= snap_seg;
            dp_q         <= snap_dp;
          end
          ON: begin
            if (cnt == ON_LAST) begin
              cnt <= '0;
              if (BLANK_CYCLES > 0) begin
                state <= BLANK;
                an_q  <= AN_OFF;
                seg_q <= SEG_OFF;
                dp_q  <= 1'b1;
              end else begin
                an_q  <= adv_an;
                seg_q <= adv_seg;
                dp_q  <= adv_dp;
                if (wrap) begin
                  digit        <= '0;
                  shadow_value <= bus.i_value;
                  shadow_dp    <= bus.i_dp;
`ifdef SWERVOLF_SSEG_LZB_EN
                  shadow_mask  <= snap_mask;
`endif
                  frame_q      <= 1'b1;
                end else begin
                  digit <= step_digit;
                end
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          BLANK: begin
            if (cnt == BL_LAST) begin
              cnt   <= '0;
              state <= ON;
              an_q  <= adv_an;
              seg_q <= adv_seg;
              dp_q  <= adv_dp;
              if (wrap) begin
                digit        <= '0;
                shadow_value <= bus.i_value;
                shadow_dp    <= bus.i_dp;
`ifdef SWERVOLF_SSEG_LZB_EN
                shadow_mask  <= snap_mask;
`endif
                frame_q      <= 1'b1;
              end else begin
                digit <= step_digit;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.o_an    = an_q;
  assign bus.o_seg   = seg_q;
  assign bus.o_dp    = dp_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_swervolf_sseg_scan.sv
// Testbench for swervolf_sseg_scan: DIGITS=8, PRESCALE=8, with one instance
// at BLANK_CYCLES=2 and a second at BLANK_CYCLES=0. Outputs sampled on the
// falling edge; inputs driven on the falling edge.
module tb_swervolf_sseg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  swervolf_sseg_scan_if #(.DIGITS(8)) bus  ();
  swervolf_sseg_scan_if #(.DIGITS(8)) bus0 ();

  swervolf_sseg_scan #(.DIGITS(8), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  swervolf_sseg_scan #(.DIGITS(8), .PRESCALE(8), .BLANK_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [6:0] seg_ref [16];

  typedef struct {
    int          adv;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;
    logic        en;
    logic [31:0] val;
    logic [7:0]  dpin;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] an, input logic [6:0] seg,
                         input logic dp, input logic frame);
    chk({name, "_an"},    32'(bus.o_an),    32'(an));
    chk({name, "_seg"},   32'(bus.o_seg),   32'(seg));
    chk({name, "_dp"},    32'(bus.o_dp),    32'(dp));
    chk({name, "_frame"}, 32'(bus.o_frame), 32'(frame));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] one;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    int         n;
    int         k;
    logic       no_gap;

    one = 8'h01;
    seg_ref[0]  = 7'b1000000; seg_ref[1]  = 7'b1111001;
    seg_ref[2]  = 7'b0100100; seg_ref[3]  = 7'b0110000;
    seg_ref[4]  = 7'b0011001; seg_ref[5]  = 7'b0010010;
    seg_ref[6]  = 7'b0000010; seg_ref[7]  = 7'b1111000;
    seg_ref[8]  = 7'b0000000; seg_ref[9]  = 7'b0010000;
    seg_ref[10] = 7'b0001000; seg_ref[11] = 7'b0000011;
    seg_ref[12] = 7'b1000110; seg_ref[13] = 7'b0100001;
    seg_ref[14] = 7'b0000110; seg_ref[15] = 7'b0001110;

    // adv, an, seg, dp, frame, then inputs applied after the check
    vt[0]  = '{1, 8'hFE, 7'b1000000, 1'b1, 1'b1, 1'b1, 32'h76543210, 8'h00};
    vt[1]  = '{1, 8'hFE, 7'b1000000, 1'b1, 1'b0, 1'b1, 32'h76543210, 8'h00};
    vt[2]  = '{4, 8'hFE, 7'b1000000, 1'b1, 1'b0, 1'b1, 32'h76543210, 8'h00};
    vt[3]  = '{1, 8'hFF, 7'h7F,      1'b1, 1'b0, 1'b1, 32'h76543210, 8'h00};
    vt[4]  = '{1, 8'hFF, 7'h7F,      1'b1, 1'b0, 1'b1, 32'h76543210, 8'h00};
    vt[5]  = '{1, 8'hFD, 7'b1111001, 1'b1, 1'b0, 1'b1, 32'h76543210, 8'h00};
    vt[6]  = '{8, 8'hFB, 7'b0100100, 1'b1, 1'b0, 1'b1, 32'h76543210, 8'h00};
    vt[7]  = '{8, 8'hF7, 7'b0110000, 1'b1, 1'b0, 1'b1, 32'h76543210, 8'h00};
    vt[8]  = '{8, 8'hEF, 7'b0011001, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 8'h01};
    vt[9]  = '{8, 8'hDF, 7'b0010010, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 8'h01};
    vt[10] = '{8, 8'hBF, 7'b0000010, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 8'h01};
    vt[11] = '{8, 8'h7F, 7'b1111000, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 8'h01};
    vt[12] = '{7, 8'hFF, 7'h7F,      1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 8'h01};
    vt[13] = '{1, 8'hFE, 7'b0001110, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 8'h01};
    vt[14] = '{1, 8'hFE, 7'b0001110, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 8'h01};
    vt[15] = '{7, 8'hFD, 7'b0001110, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 8'h01};
    vt[16] = '{8, 8'hFB, 7'b0001110, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 8'h01};

    bus.i_en = 1'b0;  bus.i_value = '0;  bus.i_dp = '0;
    bus0.i_en = 1'b0; bus0.i_value = '0; bus0.i_dp = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("reset", 8'hFF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("idle_after_reset", 8'hFF, 7'h7F, 1'b1, 1'b0);

    // Async reset while digit 3 is lit.
    bus.i_en = 1'b1; bus.i_value = 32'h76543210; bus.i_dp = 8'h00;
    repeat (26) @(negedge clk);
    chk_out("pre_rst_digit3", 8'hF7, 7'b0110000, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 8'hFF, 7'h7F, 1'b1, 1'b0);
    bus.i_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("post_rst_idle", 8'hFF, 7'h7F, 1'b1, 1'b0);

    // Main scan table: one full frame, mid-frame value change, next frame.
    bus.i_en = 1'b1; bus.i_value = 32'h76543210; bus.i_dp = 8'h00;
    for (int i = 0; i < 17; i++) begin
      repeat (vt[i].adv) @(negedge clk);
      chk_out($sformatf("scan_v%0d", i), vt[i].an, vt[i].seg, vt[i].dp, vt[i].frame);
      bus.i_en    = vt[i].en;
      bus.i_value = vt[i].val;
      bus.i_dp    = vt[i].dpin;
    end

    // Next frame pulse must arrive exactly 64 cycles after the one at cycle 65.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_frame !== 1'b1 && n < 200);
    chk("frame_period", 32'(n), 32'd48);

    // Drop enable during digit 2 ON, then re-enable.
    repeat (17) @(negedge clk);
    chk_out("dis_digit2", 8'hFB, 7'b0001110, 1'b1, 1'b0);
    bus.i_en = 1'b0;
    @(negedge clk);
    chk_out("dis_idle", 8'hFF, 7'h7F, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk_out("dis_idle_hold", 8'hFF, 7'h7F, 1'b1, 1'b0);
    bus.i_en = 1'b1;
    @(negedge clk);
    chk_out("reenable", 8'hFE, 7'b0001110, 1'b0, 1'b1);

    // Leading zeros: value 0x000000A0.
    bus.i_en = 1'b0; bus.i_value = 32'h000000A0; bus.i_dp = 8'h00;
    @(negedge clk);
    bus.i_en = 1'b1;
    @(negedge clk);
    chk_out("lz_d0", 8'hFE, 7'b1000000, 1'b1, 1'b1);
    for (int d = 1; d < 8; d++) begin
      repeat (8) @(negedge clk);
      if (d == 1) begin
        chk_out("lz_d1", 8'hFD, 7'b0001000, 1'b1, 1'b0);
      end else begin
`ifdef SWERVOLF_SSEG_LZB_EN
        chk_out($sformatf("lz_d%0d", d), 8'hFF, 7'h7F, 1'b1, 1'b0);
`else
        chk_out($sformatf("lz_d%0d", d), ~(one << d), 7'b1000000, 1'b1, 1'b0);
`endif
      end
    end
    bus.i_en = 1'b0;

    // Zero-blank instance: 8 cycles per digit, no gap, 64-cycle frame.
    bus0.i_en = 1'b1; bus0.i_value = 32'h76543210; bus0.i_dp = 8'h00;
    no_gap = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      k       = ((c - 1) / 8) % 8;
      exp_an  = ~(one << k);
      exp_seg = seg_ref[k];
      if (bus0.o_an === 8'hFF) no_gap = 1'b0;
      chk($sformatf("b0_c%0d_an", c),    32'(bus0.o_an),    32'(exp_an));
      chk($sformatf("b0_c%0d_seg", c),   32'(bus0.o_seg),   32'(exp_seg));
      chk($sformatf("b0_c%0d_frame", c), 32'(bus0.o_frame), 32'((c == 1) || (c == 65)));
    end
    chk("b0_no_gap", 32'(no_gap), 32'd1);
    bus0.i_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
